input_pio_debounce: RTL



---
 rtl/input_pio_pkg.sv | 37 +++
 rtl/input_pio_debounce_bit.sv | 85 ++++++++
 rtl/input_pio_debounce.sv | 119 +++++++++++
 3 files changed

// File: rtl/input_pio_pkg.sv
// -----------------------------------------------------------------------------
// input_pio_pkg
// Shared constants for the KEY/SW input PIO: Avalon word addresses, the field
// layout common to DATA/MASK/EDGE, the debounce counter width and a helper
// that packs switch and key bits into a register word.
// -----------------------------------------------------------------------------
package input_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE     = 2'd2;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd3;

  localparam int SW_LSB  = 0;
  localparam int KEY_LSB = 16;
  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 4;
  localparam int NUM_IN  = NUM_SW + NUM_KEY;
  localparam int CNT_W   = 20;

  // Bits of DATA/MASK/EDGE that exist; everything else reads 0.
  localparam logic [31:0] FIELD_MASK = 32'h000F_03FF;

  // Internal input vectors are ordered {keys, switches}. Switches record an
  // event on either stable transition, keys only on a press.
  localparam logic [NUM_IN-1:0] FALL_EVENT_EN = {{NUM_KEY{1'b0}}, {NUM_SW{1'b1}}};

  function automatic logic [31:0] packFields(input logic [NUM_SW-1:0]  swBits,
                                             input logic [NUM_KEY-1:0] keyBits);
    logic [31:0] word;
    word = '0;
    word[SW_LSB +: NUM_SW]   = swBits;
    word[KEY_LSB +: NUM_KEY] = keyBits;
    return word;
  endfunction

endpackage

// File: rtl/input_pio_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One raw board input: 2-flop synchroniser, optional polarity inversion, a
// per-bit run counter and the debounced stable flop.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   raw      : asynchronous board input
//   thresh   : debounce length T (0 is treated as 1)
//   stable   : debounced value (after inversion)
//   rise     : high in the cycle whose edge flips stable 0->1
//   fall     : high in the cycle whose edge flips stable 1->0
// -----------------------------------------------------------------------------
module debounce_bit
  import input_pio_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw,
  input  logic [CNT_W-1:0] thresh,
  output logic             stable,
  output logic             rise,
  output logic             fall
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] limit;
  logic             synced;
  logic             flip;

  // Synchroniser flops reset to the idle level of the raw pin so that an
  // inverted (active-low) key does not look pressed right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign synced = sync2_q ^ INVERT;

  // T-1 with T = max(thresh, 1).
  assign limit = (thresh == '0) ? '0 : thresh - CNT_W'(1);

  // Count while the synced value disagrees with the stable one. The >= test
  // lets a freshly shrunk threshold flip a long-running count immediately.
  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q >= limit) begin
        flip = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_d = stable_q ^ flip;

  // Counter and stable value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  assign rise   = flip & ~stable_q;
  assign fall   = flip &  stable_q;

endmodule

// File: rtl/input_pio_debounce.sv
// -----------------------------------------------------------------------------
// input_pio_debounce
// Avalon-MM slave that debounces KEY[3:0] (active-low) and SW[9:0], latches
// their changes in a write-1-to-clear EDGE register and raises a level irq.
//   clk, reset_n       : CLOCK_50 and asynchronous active-low reset
//   avs_address        : word address (0 DATA, 1 MASK, 2 EDGE, 3 DEBOUNCE)
//   avs_read/avs_write : strobes; avs_writedata write data
//   avs_readdata       : read data, latency 1, held until the next read
//   irq                : registered |(EDGE & MASK)
//   key_n, sw          : raw asynchronous board inputs
// -----------------------------------------------------------------------------
module input_pio_debounce
  import input_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw
);

  localparam logic [CNT_W-1:0] DEBOUNCE_RST = CNT_W'(DEBOUNCE_CYCLES);

  logic [NUM_IN-1:0] rawVec;
  logic [NUM_IN-1:0] stableVec;
  logic [NUM_IN-1:0] riseVec;
  logic [NUM_IN-1:0] fallVec;
  logic [NUM_IN-1:0] eventVec;

  logic [31:0]      mask_q,     mask_d;
  logic [31:0]      edge_q,     edge_d;
  logic [CNT_W-1:0] debounce_q, debounce_d;
  logic [31:0]      readData_q, readData_d;
  logic             irq_q,      irq_d;

  logic [31:0] dataWord;
  logic [31:0] edgeSet;
  logic [31:0] edgeClr;
  logic [31:0] wrField;

  assign rawVec = {key_n, sw};

  // Keys are active-low on the board, so they are inverted after sync.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
    debounce_bit #(
      .INVERT (i >= NUM_SW)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (rawVec[i]),
      .thresh  (debounce_q),
      .stable  (stableVec[i]),
      .rise    (riseVec[i]),
      .fall    (fallVec[i])
    );
  end

  assign eventVec = riseVec | (fallVec & FALL_EVENT_EN);
  assign dataWord = packFields(stableVec[NUM_SW-1:0], stableVec[NUM_IN-1:NUM_SW]);
  assign edgeSet  = packFields(eventVec[NUM_SW-1:0], eventVec[NUM_IN-1:NUM_SW]);
  assign wrField  = avs_writedata & FIELD_MASK;

  // Register writes, EDGE set/clear and the read mux. The read mux looks at
  // the current register values, so a same-cycle write is not yet visible.
  always_comb begin
    mask_d     = mask_q;
    debounce_d = debounce_q;
    readData_d = readData_q;
    edgeClr    = '0;
    if (avs_write) begin
      case (avs_address)
        ADDR_MASK:     mask_d     = wrField;
        ADDR_EDGE:     edgeClr    = wrField;
        ADDR_DEBOUNCE: debounce_d = avs_writedata[CNT_W-1:0];
        default:       ;
      endcase
    end
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:     readData_d = dataWord;
        ADDR_MASK:     readData_d = mask_q;
        ADDR_EDGE:     readData_d = edge_q;
        ADDR_DEBOUNCE: readData_d = {{(32-CNT_W){1'b0}}, debounce_q};
        default:       readData_d = '0;
      endcase
    end
    // A new event wins over a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~edgeClr) | edgeSet;
    irq_d  = |(edge_q & mask_q);
  end

  // Register file, read data and interrupt flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      debounce_q <= DEBOUNCE_RST;
      readData_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      debounce_q <= debounce_d;
      readData_q <= readData_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readData_q;
  assign irq          = irq_q;

endmodule
